// File: rtl/adder_cs_pkg.sv
// adder_cs_pkg: sizing helpers and parameter bounds for the carry-save multi-operand adder
package adder_cs_pkg;
  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;
  localparam int NOPS_MIN = 3;
  localparam int NOPS_MAX = 8;
  function automatic int cs_vecs(input int nops, input int level);
    int n;
    n = nops;
    for (int i = 0; i < level; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction
  function automatic int cs_levels(input int nops);
    int n, l;
    n = nops;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction
  function automatic int cs_ow(input int width, input int nops);
    return width + $clog2(nops);
  endfunction
endpackage

// File: rtl/adder_cs_row.sv
// adder_cs_row: combinational 3:2 carry-save row, carry pre-shifted into its weight
module adder_cs_row #(
  parameter int W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  assign sum = a ^ b ^ c;
  assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
endmodule

// File: rtl/adder_cs_multi_pipe.sv
// adder_cs_multi_pipe: pipelined NOPS-operand carry-save adder with valid/ready handshake
module adder_cs_multi_pipe
  import adder_cs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NOPS = 4,
  parameter int SIGNED = 0,
  localparam int OW = cs_ow(WIDTH, NOPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NOPS*WIDTH-1:0] in_ops,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_sum
);
  localparam int LEVELS = cs_levels(NOPS);
  logic adv;
  logic [LEVELS:0] v, ci;
  logic [OW-1:0] e [NOPS];
  logic [OW-1:0] x [NOPS];
  logic [OW-1:0] f0, f1;
  genvar l, g, k;
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || NOPS < NOPS_MIN || NOPS > NOPS_MAX) begin : bad_params
    $error("adder_cs_multi_pipe: WIDTH or NOPS out of range");
  end
  // one global stall: every stage moves only when the output slot can drain
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  for (k = 0; k < NOPS; k++) begin : ext
    assign e[k] = {{(OW-WIDTH){SIGNED != 0 && in_ops[k*WIDTH+WIDTH-1]}}, in_ops[k*WIDTH +: WIDTH]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      ci <= '0;
      for (int i = 0; i < NOPS; i++) x[i] <= '0;
    end else if (adv) begin
      v <= {v[LEVELS-1:0], in_valid};
      ci <= {ci[LEVELS-1:0], in_cin};
      for (int i = 0; i < NOPS; i++) x[i] <= e[i];
    end
  end
  for (l = 0; l < LEVELS; l++) begin : lv
    localparam int N = cs_vecs(NOPS, l);
    localparam int G = N / 3;
    localparam int M = 2 * G + N % 3;
    logic [OW-1:0] d [N];
    logic [OW-1:0] s [M];
    logic [OW-1:0] r [M];
    for (k = 0; k < N; k++) begin : src
      if (l == 0) begin : first
        assign d[k] = x[k];
      end else begin : prev
        assign d[k] = lv[l-1].r[k];
      end
    end
    for (g = 0; g < G; g++) begin : row
      adder_cs_row #(.W(OW)) u_row (
        .a(d[3*g]),
        .b(d[3*g+1]),
        .c(d[3*g+2]),
        .sum(s[2*g]),
        .carry(s[2*g+1])
      );
    end
    for (k = 0; k < N % 3; k++) begin : pass
      assign s[2*G+k] = d[3*G+k];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < M; i++) r[i] <= '0;
      else if (adv) for (int i = 0; i < M; i++) r[i] <= s[i];
    end
    if (l == LEVELS - 1) begin : last
      assign f0 = r[0];
      assign f1 = r[1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum <= '0;
    end else if (adv) begin
      out_valid <= v[LEVELS];
      out_sum <= f0 + f1 + {{(OW-1){1'b0}}, ci[LEVELS]};
    end
  end
endmodule
